// File: rtl/instr_queue.sv
// instr_queue: circular FIFO of decoded control words plus rvfi sideband between
// decode and dispatch. Same-cycle ld_iq/iq_ack on the write side, valid/ready on
// the read side. A flush empties the queue in one cycle.
module instr_queue #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CW_WIDTH   = 128,
  parameter int unsigned RVFI_WIDTH = 160
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    ld_iq,
  input  logic [CW_WIDTH-1:0]     cw_in,
  input  logic [RVFI_WIDTH-1:0]   rvfi_in,
  output logic                    iq_ack,
  input  logic                    deq_rdy,
  output logic                    deq_valid,
  output logic [CW_WIDTH-1:0]     cw_out,
  output logic [RVFI_WIDTH-1:0]   rvfi_out,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic [31:0]             stall_cycles
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [CW_WIDTH-1:0]   cw_mem_q   [DEPTH];
  logic [RVFI_WIDTH-1:0] rvfi_mem_q [DEPTH];

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     stall_q, stall_d;
  logic            deq;

  // Handshakes: iq_ack deliberately ignores deq_rdy, so a full queue rejects
  // an enqueue even when the head is leaving in the same cycle.
  always_comb begin
    full      = (count_q == CntW'(DEPTH));
    empty     = (count_q == '0);
    iq_ack    = ld_iq & ~full & ~flush;
    deq_valid = ~empty;
    deq       = deq_valid & deq_rdy & ~flush;
    cw_out    = cw_mem_q[head_q];
    rvfi_out  = rvfi_mem_q[head_q];
    count        = count_q;
    stall_cycles = stall_q;
  end

  // Next-state for pointers, occupancy and the saturating stall counter.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    stall_d = stall_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (iq_ack) tail_d = tail_q + 1'b1;
      if (deq)    head_d = head_q + 1'b1;
      if (iq_ack && !deq) begin
        count_d = count_q + 1'b1;
      end else if (!iq_ack && deq) begin
        count_d = count_q - 1'b1;
      end
    end
    // Flush cycles with ld_iq held count as stalls too.
    if (ld_iq && !iq_ack && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stall_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      stall_q <= stall_d;
    end
  end

  // Entry storage: cleared by reset only; flush leaves contents in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        cw_mem_q[i]   <= '0;
        rvfi_mem_q[i] <= '0;
      end
    end else if (iq_ack) begin
      cw_mem_q[tail_q]   <= cw_in;
      rvfi_mem_q[tail_q] <= rvfi_in;
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Bench for instr_queue: directed scenarios plus a randomized run, all checked
// against a queue-based reference model of the FIFO contents and stall count.
module tb_instr_queue;

  localparam int DEPTH = 8;
  localparam int CW    = 128;
  localparam int RV    = 160;
  localparam int CNTW  = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst, flush, ld_iq, deq_rdy;
  logic [CW-1:0]   cw_in;
  logic [RV-1:0]   rvfi_in;
  logic            iq_ack, deq_valid, full, empty;
  logic [CW-1:0]   cw_out;
  logic [RV-1:0]   rvfi_out;
  logic [CNTW-1:0] count;
  logic [31:0]     stall_cycles;

  int checks   = 0;
  int failures = 0;

  // Reference model.
  logic [CW-1:0] m_cw[$];
  logic [RV-1:0] m_rv[$];
  logic [31:0]   m_stall;

  instr_queue #(.DEPTH(DEPTH), .CW_WIDTH(CW), .RVFI_WIDTH(RV)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .ld_iq        (ld_iq),
    .cw_in        (cw_in),
    .rvfi_in      (rvfi_in),
    .iq_ack       (iq_ack),
    .deq_rdy      (deq_rdy),
    .deq_valid    (deq_valid),
    .cw_out       (cw_out),
    .rvfi_out     (rvfi_out),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] rand_cw();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [RV-1:0] rand_rv();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive one cycle's inputs just after the falling edge.
  task automatic apply(input logic ld, input logic [CW-1:0] c, input logic [RV-1:0] r,
                       input logic rdy, input logic fl);
    @(negedge clk);
    ld_iq = ld; cw_in = c; rvfi_in = r; deq_rdy = rdy; flush = fl;
    #1;
  endtask

  // Advance the model by the current inputs, then take the rising edge.
  task automatic commit();
    bit ack, dq;
    ack = ld_iq && (m_cw.size() < DEPTH) && !flush;
    dq  = (m_cw.size() > 0) && deq_rdy && !flush;
    if (ld_iq && !ack && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (flush) begin
      m_cw.delete(); m_rv.delete();
    end else begin
      if (dq) begin void'(m_cw.pop_front()); void'(m_rv.pop_front()); end
      if (ack) begin m_cw.push_back(cw_in); m_rv.push_back(rvfi_in); end
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; ld_iq = 0; deq_rdy = 0; flush = 0; cw_in = '0; rvfi_in = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_cw.delete(); m_rv.delete(); m_stall = '0;
    #1;
    checks += 8;
    if (count !== '0) begin failures++; $display("FAIL reset_count got %0d want 0", count); end
    if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got %b want 1", empty); end
    if (full !== 1'b0) begin failures++; $display("FAIL reset_full got %b want 0", full); end
    if (deq_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", deq_valid); end
    if (stall_cycles !== '0) begin failures++; $display("FAIL reset_stall got %0d want 0", stall_cycles); end
    if (cw_out !== '0) begin failures++; $display("FAIL reset_cw got %0h want 0", cw_out); end
    if (rvfi_out !== '0) begin failures++; $display("FAIL reset_rvfi got %0h want 0", rvfi_out); end
    if (iq_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got %b want 0", iq_ack); end
  endtask

  task automatic test_first_enq();
    logic [CW-1:0] a;
    a = rand_cw();
    apply(1, a, rand_rv(), 0, 0);
    checks++;
    if (iq_ack !== 1'b1) begin failures++; $display("FAIL first_ack got %b want 1", iq_ack); end
    commit();
    apply(0, '0, '0, 1, 0);
    checks += 3;
    if (deq_valid !== 1'b1) begin failures++; $display("FAIL first_valid got %b want 1", deq_valid); end
    if (cw_out !== a) begin failures++; $display("FAIL first_cw got %0h want %0h", cw_out, a); end
    if (count !== CNTW'(1)) begin failures++; $display("FAIL first_count got %0d want 1", count); end
    commit();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      apply(1, CW'(i), RV'(i + 100), 0, 0);
      checks++;
      if (iq_ack !== 1'b1) begin failures++; $display("FAIL fill_ack[%0d] got %b want 1", i, iq_ack); end
      commit();
    end
    apply(1, CW'(DEPTH), RV'(DEPTH + 100), 0, 0);
    checks += 3;
    if (full !== 1'b1) begin failures++; $display("FAIL fill_full got %b want 1", full); end
    if (count !== CNTW'(DEPTH)) begin failures++; $display("FAIL fill_count got %0d want %0d", count, DEPTH); end
    if (iq_ack !== 1'b0) begin failures++; $display("FAIL fill_ack9 got %b want 0", iq_ack); end
    commit();
    for (int i = 0; i < DEPTH; i++) begin
      apply(0, '0, '0, 1, 0);
      if (i == 0) begin
        checks++;
        if (stall_cycles !== 32'd1) begin failures++; $display("FAIL fill_stall got %0d want 1", stall_cycles); end
      end
      checks += 2;
      if (cw_out !== CW'(i)) begin failures++; $display("FAIL drain_cw[%0d] got %0h want %0h", i, cw_out, i); end
      if (rvfi_out !== RV'(i + 100)) begin failures++; $display("FAIL drain_rvfi[%0d] got %0h want %0h", i, rvfi_out, i + 100); end
      commit();
    end
    apply(0, '0, '0, 0, 0);
    checks++;
    if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got %b want 1", empty); end
    commit();
  endtask

  task automatic test_steady_wrap();
    for (int i = 0; i < 4; i++) begin apply(1, rand_cw(), rand_rv(), 0, 0); commit(); end
    for (int i = 0; i < 20; i++) begin
      apply(1, rand_cw(), rand_rv(), 1, 0);
      checks += 4;
      if (iq_ack !== 1'b1) begin failures++; $display("FAIL wrap_ack[%0d] got %b want 1", i, iq_ack); end
      if (count !== CNTW'(4)) begin failures++; $display("FAIL wrap_count[%0d] got %0d want 4", i, count); end
      if (cw_out !== m_cw[0]) begin failures++; $display("FAIL wrap_cw[%0d] got %0h want %0h", i, cw_out, m_cw[0]); end
      if (rvfi_out !== m_rv[0]) begin failures++; $display("FAIL wrap_rvfi[%0d] got %0h want %0h", i, rvfi_out, m_rv[0]); end
      commit();
    end
  endtask

  task automatic test_full_deq();
    logic [CW-1:0] c;
    logic [RV-1:0] r;
    while (m_cw.size() < DEPTH) begin apply(1, rand_cw(), rand_rv(), 0, 0); commit(); end
    c = rand_cw(); r = rand_rv();
    apply(1, c, r, 1, 0);
    checks += 2;
    if (full !== 1'b1) begin failures++; $display("FAIL fulldeq_full got %b want 1", full); end
    if (iq_ack !== 1'b0) begin failures++; $display("FAIL fulldeq_ack got %b want 0", iq_ack); end
    commit();
    apply(1, c, r, 0, 0);
    checks += 2;
    if (count !== CNTW'(DEPTH - 1)) begin failures++; $display("FAIL fulldeq_count got %0d want %0d", count, DEPTH - 1); end
    if (iq_ack !== 1'b1) begin failures++; $display("FAIL fulldeq_ack2 got %b want 1", iq_ack); end
    commit();
  endtask

  task automatic test_flush();
    logic [31:0] s0;
    while (m_cw.size() > 5) begin apply(0, '0, '0, 1, 0); commit(); end
    apply(1, rand_cw(), rand_rv(), 1, 1);
    s0 = stall_cycles;
    checks += 2;
    if (count !== CNTW'(5)) begin failures++; $display("FAIL flush_pre_count got %0d want 5", count); end
    if (iq_ack !== 1'b0) begin failures++; $display("FAIL flush_ack got %b want 0", iq_ack); end
    commit();
    apply(0, '0, '0, 0, 0);
    checks += 3;
    if (count !== '0) begin failures++; $display("FAIL flush_count got %0d want 0", count); end
    if (deq_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got %b want 0", deq_valid); end
    if (stall_cycles !== m_stall) begin failures++; $display("FAIL flush_stall got %0d want %0d (before %0d)", stall_cycles, m_stall, s0); end
    commit();
  endtask

  task automatic test_no_bypass();
    logic [CW-1:0] b;
    b = rand_cw();
    apply(1, b, rand_rv(), 1, 0);
    checks += 3;
    if (deq_valid !== 1'b0) begin failures++; $display("FAIL nobyp_valid0 got %b want 0", deq_valid); end
    if (cw_out === b) begin failures++; $display("FAIL nobyp_cw0 got %0h want not %0h", cw_out, b); end
    if (iq_ack !== 1'b1) begin failures++; $display("FAIL nobyp_ack got %b want 1", iq_ack); end
    commit();
    apply(0, '0, '0, 1, 0);
    checks += 2;
    if (deq_valid !== 1'b1) begin failures++; $display("FAIL nobyp_valid1 got %b want 1", deq_valid); end
    if (cw_out !== b) begin failures++; $display("FAIL nobyp_cw1 got %0h want %0h", cw_out, b); end
    commit();
    apply(0, '0, '0, 0, 0);
    checks++;
    if (count !== '0) begin failures++; $display("FAIL nobyp_count got %0d want 0", count); end
    commit();
  endtask

  task automatic test_random();
    logic          ld, rdy, fl, held;
    logic [CW-1:0] c;
    logic [RV-1:0] r;
    bit            eack;
    held = 0;
    for (int i = 0; i < 400; i++) begin
      if (!held) begin
        ld = ($urandom_range(0, 3) != 0); c = rand_cw(); r = rand_rv();
      end
      rdy = ($urandom_range(0, 2) == 0);
      fl  = ($urandom_range(0, 31) == 0);
      apply(ld, c, r, rdy, fl);
      eack = ld && (m_cw.size() < DEPTH) && !fl;
      checks += 6;
      if (iq_ack !== eack) begin failures++; $display("FAIL rnd_ack[%0d] got %b want %b", i, iq_ack, eack); end
      if (count !== CNTW'(m_cw.size())) begin failures++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, count, m_cw.size()); end
      if (deq_valid !== (m_cw.size() > 0)) begin failures++; $display("FAIL rnd_valid[%0d] got %b want %b", i, deq_valid, m_cw.size() > 0); end
      if (full !== (m_cw.size() == DEPTH)) begin failures++; $display("FAIL rnd_full[%0d] got %b", i, full); end
      if (empty !== (m_cw.size() == 0)) begin failures++; $display("FAIL rnd_empty[%0d] got %b", i, empty); end
      if (stall_cycles !== m_stall) begin failures++; $display("FAIL rnd_stall[%0d] got %0d want %0d", i, stall_cycles, m_stall); end
      if (m_cw.size() > 0) begin
        checks += 2;
        if (cw_out !== m_cw[0]) begin failures++; $display("FAIL rnd_cw[%0d] got %0h want %0h", i, cw_out, m_cw[0]); end
        if (rvfi_out !== m_rv[0]) begin failures++; $display("FAIL rnd_rvfi[%0d] got %0h want %0h", i, rvfi_out, m_rv[0]); end
      end
      held = ld && !eack;
      commit();
    end
  endtask

  initial begin
    rst = 1'b1; flush = 0; ld_iq = 0; deq_rdy = 0; cw_in = '0; rvfi_in = '0;
    m_stall = '0;
    test_reset();
    test_first_enq();
    test_fill_drain();
    test_steady_wrap();
    test_full_deq();
    test_flush();
    test_no_bypass();
    test_random();
    // Reset with entries present must also clear storage.
    for (int i = 0; i < 3; i++) begin apply(1, rand_cw(), rand_rv(), 0, 0); commit(); end
    test_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
